video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width, in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch, in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width, in lines.
REQ-008 Parameter V_BP, 33, vertical back porch, in lines.
REQ-009 Parameter HSYNC_POL, 0, asserted hsync level (0 = active-low).
REQ-010 Parameter VSYNC_POL, 0, asserted vsync level (0 = active-low).
REQ-011 clk  input  1  single clock; all logic on posedge clk.
REQ-012 reset  input  1  synchronous, active-high reset.
REQ-013 ce  input  1  pixel clock enable; one pixel is advanced per cycle with ce=1.
REQ-014 hsync  output  1  registered horizontal sync, at HSYNC_POL level when asserted.
REQ-015 vsync  output  1  registered vertical sync, at VSYNC_POL level when asserted.
REQ-016 data_en  output  1  high for visible pixels only.
REQ-017 x  output  XW=$clog2(H_ACTIVE)  visible pixel column.
REQ-018 y  output  YW=$clog2(V_ACTIVE)  visible line row.
REQ-019 line_start  output  1  one-pixel pulse at hc==0 of every line, blanking lines included.
REQ-020 frame_start  output  1  one-pixel pulse at hc==0, vc==0.

Function
REQ-021 Horizontal counter hc SHALL run 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters) and advance only when ce=1.
REQ-022 Horizontal phase order: active [0,H_ACTIVE), front porch, sync, back porch; hc wraps to 0 after H_TOTAL-1.
REQ-023 Vertical counter vc SHALL run 0..V_TOTAL-1 and advance only on a ce cycle where hc==H_TOTAL-1. It wraps with the same phase order.
REQ-024 hsync asserted iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
REQ-025 vsync asserted iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; vsync edges align to hc==0.
REQ-026 data_en = (hc<H_ACTIVE)&(vc<V_ACTIVE).
REQ-027 x = hc when hc<H_ACTIVE, else 0. y = vc when vc<V_ACTIVE, else 0.
REQ-028 All outputs are registered with 1-cycle latency: they update on the cycle after the counters take a value, and only on ce=1 cycles.
REQ-029 With ce=0, counters and all outputs hold, line_start and frame_start included. A pulse therefore lasts exactly one ce-qualified pixel.
REQ-030 Counter widths SHALL be $clog2(total)+1 bits, so there is no overflow at any legal parameter set.
REQ-031 Every parameter SHALL be >=1; any other value is an elaboration-time error.
REQ-032 Simultaneous hc wrap and vc wrap SHALL produce frame_start and line_start on the same pixel.

Reset
REQ-033 While reset=1: hc=0, vc=0, data_en=0, x=0, y=0, line_start=0, frame_start=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
REQ-034 Reset overrides ce. Reset mid-frame abandons the frame.
REQ-035 The first ce=1 cycle after release emits pixel (0,0): data_en=1, line_start=1, frame_start=1.

Structure
REQ-036 A shared header video_timing_modes.vh SHALL hold mode presets as parameter sets: 640x480@60 (default), 1280x720@60, 1920x1080@30.
REQ-037 Each axis SHALL be an instance of one sub-module, video_timing_axis.
REQ-038 video_timing_axis parameters: ACTIVE, FP, SYNC, BP. Ports: clk, reset, step, count, wrap, in_active, in_sync.
REQ-039 The horizontal instance has step=ce. The vertical instance has step = ce & horizontal wrap.

Verification
REQ-040 Default parameters, ce=1: frame_start pulses every 420000 cycles, line_start every 800 cycles, and data_en is high 640 cycles/line on 480 lines/frame.
REQ-041 Default parameters: hsync is low for exactly 96 cycles starting 656 cycles after line_start. vsync is low for 2 lines (1600 cycles) starting at line 490.
REQ-042 ce toggling 1,0,1,0: frame_start period is 840000 cycles, and each pulse is 1 ce-qualified pixel wide (2 clk cycles since ce=0 holds it).
REQ-043 Reset asserted at x=300, y=200, then released with ce=1: the next output cycle has x=0, y=0, frame_start=1, and sync outputs are inactive during reset.
REQ-044 Minimal set H=4/1/1/1, V=2/1/1/1, HSYNC_POL=1: the 7x5 sequence matches a cycle-exact reference model over 3 frames, with hsync high only at hc=5.
REQ-045 1280x720 preset: frame period is 1650*750 = 1237500 cycles, and x reaches 1279 with no glitch on the wrap to blanking.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared types, mode presets and width helpers
package video_timing_gen_pkg;

  `include "video_timing_modes.vh"

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_t;

  // one spare bit so total itself is representable at any parameter set
  function automatic int cnt_width(input int total);
    return $clog2(total) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one timing axis: position counter plus phase tracker
module video_timing_axis
  import video_timing_gen_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  localparam int TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int CW    = cnt_width(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          in_active,
  output logic          in_sync
);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
    $error("video_timing_axis: every segment length must be at least 1");
  end

  localparam logic [CW-1:0] END_ACTIVE = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] END_FP     = CW'(ACTIVE + FP - 1);
  localparam logic [CW-1:0] END_SYNC   = CW'(ACTIVE + FP + SYNC - 1);
  localparam logic [CW-1:0] END_BP     = CW'(TOTAL - 1);

  phase_t        phase;
  phase_t        phase_nxt;
  phase_t        seg_next;
  logic [CW-1:0] seg_end;
  logic [CW-1:0] count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_ACTIVE;
      count <= '0;
    end else begin
      phase <= phase_nxt;
      count <= count_nxt;
    end
  end

  // phase advances on the step that leaves the last position of its segment
  always_comb begin
    seg_end   = END_BP;
    seg_next  = PH_ACTIVE;
    phase_nxt = phase;
    count_nxt = count;
    case (phase)
      PH_ACTIVE: begin seg_end = END_ACTIVE; seg_next = PH_FP;     end
      PH_FP:     begin seg_end = END_FP;     seg_next = PH_SYNC;   end
      PH_SYNC:   begin seg_end = END_SYNC;   seg_next = PH_BP;     end
      default:   begin seg_end = END_BP;     seg_next = PH_ACTIVE; end
    endcase
    if (step) begin
      count_nxt = (count == END_BP) ? '0 : count + 1'b1;
      if (count == seg_end) phase_nxt = seg_next;
    end
  end

  assign wrap      = step && (count == END_BP);
  assign in_active = (phase == PH_ACTIVE);
  assign in_sync   = (phase == PH_SYNC);

endmodule

// File: rtl/video_timing_modes.vh
// rtl/video_timing_modes.vh - display mode presets as per-axis parameter sets
`ifndef VIDEO_TIMING_MODES_VH
`define VIDEO_TIMING_MODES_VH

// 640x480@60 (default mode), negative syncs
localparam int  VGA_H_ACTIVE  = 640;
localparam int  VGA_H_FP      = 16;
localparam int  VGA_H_SYNC    = 96;
localparam int  VGA_H_BP      = 48;
localparam int  VGA_V_ACTIVE  = 480;
localparam int  VGA_V_FP      = 10;
localparam int  VGA_V_SYNC    = 2;
localparam int  VGA_V_BP      = 33;
localparam bit  VGA_HSYNC_POL = 1'b0;
localparam bit  VGA_VSYNC_POL = 1'b0;

// 1280x720@60, positive syncs
localparam int  HD720_H_ACTIVE  = 1280;
localparam int  HD720_H_FP      = 110;
localparam int  HD720_H_SYNC    = 40;
localparam int  HD720_H_BP      = 220;
localparam int  HD720_V_ACTIVE  = 720;
localparam int  HD720_V_FP      = 5;
localparam int  HD720_V_SYNC    = 5;
localparam int  HD720_V_BP      = 20;
localparam bit  HD720_HSYNC_POL = 1'b1;
localparam bit  HD720_VSYNC_POL = 1'b1;

// 1920x1080@30, positive syncs
localparam int  HD1080_H_ACTIVE  = 1920;
localparam int  HD1080_H_FP      = 88;
localparam int  HD1080_H_SYNC    = 44;
localparam int  HD1080_H_BP      = 148;
localparam int  HD1080_V_ACTIVE  = 1080;
localparam int  HD1080_V_FP      = 4;
localparam int  HD1080_V_SYNC    = 5;
localparam int  HD1080_V_BP      = 36;
localparam bit  HD1080_HSYNC_POL = 1'b1;
localparam bit  HD1080_VSYNC_POL = 1'b1;

`endif

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with registered sync/enable/position outputs
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HSYNC_POL = VGA_HSYNC_POL,
  parameter bit VSYNC_POL = VGA_VSYNC_POL,
  localparam int XW = idx_width(H_ACTIVE),
  localparam int YW = idx_width(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          data_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HCW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VCW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [HCW-1:0] hc;
  logic [VCW-1:0] vc;
  logic           h_wrap;
  logic           v_wrap_unused;
  logic           h_active;
  logic           v_active;
  logic           h_in_sync;
  logic           v_in_sync;

  video_timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .reset     (reset),
    .step      (ce),
    .count     (hc),
    .wrap      (h_wrap),
    .in_active (h_active),
    .in_sync   (h_in_sync)
  );

  // the line counter moves only on the pixel that ends a line
  video_timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .reset     (reset),
    .step      (ce & h_wrap),
    .count     (vc),
    .wrap      (v_wrap_unused),
    .in_active (v_active),
    .in_sync   (v_in_sync)
  );

  // outputs describe the counter position they were sampled from, one cycle late
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      data_en     <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hsync       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
      data_en     <= h_active & v_active;
      x           <= h_active ? hc[XW-1:0] : '0;
      y           <= v_active ? vc[YW-1:0] : '0;
      line_start  <= (hc == '0);
      frame_start <= (hc == '0) && (vc == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized scoreboard bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;

  localparam int  HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int  VA = 5, VF = 1, VS = 2, VB = 2;
  localparam bit  HP = 1'b1;
  localparam bit  VP = 1'b0;
  localparam int  HT = HA + HF + HS + HB;
  localparam int  VT = VA + VF + VS + VB;
  localparam int  XW = 3;
  localparam int  YW = 3;

  typedef struct packed {
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hs;
    logic          vs;
    logic          ls;
    logic          fs;
  } out_t;

  logic          clk;
  logic          reset;
  logic          ce;
  logic          hsync;
  logic          vsync;
  logic          data_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_start;
  logic          frame_start;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HSYNC_POL (HP), .VSYNC_POL (VP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ce          (ce),
    .hsync       (hsync),
    .vsync       (vsync),
    .data_en     (data_en),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // reference: a linear pixel index over the whole frame, split into column/row arithmetically
  int   pix = 0;
  out_t model_out;

  function automatic out_t pixel_outputs(input int p);
    out_t o;
    int hc, vc;
    hc   = p % HT;
    vc   = p / HT;
    o.de = (hc < HA) && (vc < VA);
    o.x  = (hc < HA) ? XW'(hc) : '0;
    o.y  = (vc < VA) ? YW'(vc) : '0;
    o.hs = (hc >= HA + HF && hc < HA + HF + HS) ? HP : !HP;
    o.vs = (vc >= VA + VF && vc < VA + VF + VS) ? VP : !VP;
    o.ls = (hc == 0);
    o.fs = (p == 0);
    return o;
  endfunction

  function automatic out_t reset_outputs();
    out_t o;
    o    = '0;
    o.hs = !HP;
    o.vs = !VP;
    return o;
  endfunction

  task automatic drive(input bit r, input bit c);
    reset = r;
    ce    = c;
    if (r) begin
      pix       = 0;
      model_out = reset_outputs();
    end else if (c) begin
      model_out = pixel_outputs(pix);
      pix       = (pix + 1) % (HT * VT);
    end
    exp_q.push_back(model_out);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    out_t got, e;
    cycle++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = '{de: data_en, x: x, y: y, hs: hsync, vs: vsync, ls: line_start, fs: frame_start};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got de=%b x=%0d y=%0d hs=%b vs=%b ls=%b fs=%b, expected de=%b x=%0d y=%0d hs=%b vs=%b ls=%b fs=%b",
                 cycle, got.de, got.x, got.y, got.hs, got.vs, got.ls, got.fs,
                 e.de, e.x, e.y, e.hs, e.vs, e.ls, e.fs);
      end
    end
  end

  initial begin
    reset = 1'b1;
    ce    = 1'b0;
    // reset holds outputs inactive even with ce high
    repeat (3) drive(1'b1, 1'b1);
    // free-running for three full frames, wrap of both counters included
    repeat (3 * HT * VT + 5) drive(1'b0, 1'b1);
    // reset mid-frame, then restart
    repeat (2) drive(1'b1, 1'b0);
    repeat (4 * HT + 5) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    // alternating enable: every pulse spans two clocks
    for (int i = 0; i < 2 * HT * VT + 10; i++) drive(1'b0, (i % 2) == 0);
    // long hold with ce low
    repeat (20) drive(1'b0, 1'b0);
    // randomized enable with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(399) == 0, $urandom_range(99) < 65);
    end
    ce    = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
